// File: rtl/error_code_encoder.sv
// Transmit side of the 3-bit error-code link: sticky error flags, drop counter,
// and a two-state sender that encodes each pending snapshot onto a valid/ready handshake.
module error_code_encoder #(
  parameter logic [2:0] CODE_PARITY   = 3'd0,
  parameter logic [2:0] CODE_TIMEOUT  = 3'd3,
  parameter logic [2:0] CODE_OVERFLOW = 3'd5,
  parameter logic [2:0] CODE_MULTI    = 3'd7,
  parameter int unsigned DROP_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              parity_evt,
  input  logic              timeout_evt,
  input  logic              overflow_evt,
  output logic [2:0]        err_code,
  output logic              err_valid,
  input  logic              err_ready,
  output logic              err_multi,
  output logic [2:0]        pending,
  output logic [DROP_W-1:0] drop_cnt
);

  // state | meaning
  // IDLE  | nothing presented, waiting for a pending flag
  // SEND  | err_code/err_multi presented with err_valid=1
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [DROP_W+1:0] DROP_MAX = {2'b00, {DROP_W{1'b1}}};

  state_t            state_q, state_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              err_multi_q, err_multi_d;
  logic [2:0]        pending_q, pending_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [2:0]        evt;
  logic [2:0]        clear_mask;
  logic [2:0]        drop_hit;
  logic [1:0]        drop_inc;
  logic [DROP_W+1:0] drop_sum;
  logic              capture;
  logic              snap_multi;

  assign evt        = {overflow_evt, timeout_evt, parity_evt};
  assign snap_multi = (pending_q[0] & pending_q[1]) | (pending_q[0] & pending_q[2]) |
                      (pending_q[1] & pending_q[2]);

  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    err_multi_d = err_multi_q;
    capture     = 1'b0;

    case (state_q)
      IDLE: begin
        capture = (pending_q != 3'b000);
      end
      SEND: begin
        if (err_ready) begin
          capture = (pending_q != 3'b000);
          if (!capture) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d     = SEND;
      err_multi_d = snap_multi;
      if (snap_multi) begin
        err_code_d = CODE_MULTI;
      end else begin
        case (pending_q)
          3'b001:  err_code_d = CODE_PARITY;
          3'b010:  err_code_d = CODE_TIMEOUT;
          default: err_code_d = CODE_OVERFLOW;
        endcase
      end
    end
  end

  // Set wins over clear, so a same-cycle event of a captured type is re-armed, not dropped.
  always_comb begin
    clear_mask = capture ? pending_q : 3'b000;
    pending_d  = (pending_q & ~clear_mask) | evt;
    drop_hit   = evt & pending_q & ~clear_mask;
    drop_inc   = {1'b0, drop_hit[0]} + {1'b0, drop_hit[1]} + {1'b0, drop_hit[2]};
    drop_sum   = {2'b00, drop_cnt_q} + {{DROP_W{1'b0}}, drop_inc};
    drop_cnt_d = (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      err_code_q  <= CODE_PARITY;
      err_multi_q <= 1'b0;
      pending_q   <= 3'b000;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      err_multi_q <= err_multi_d;
      pending_q   <= pending_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign err_valid = (state_q == SEND);
  assign err_code  = err_code_q;
  assign err_multi = err_multi_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_error_code_encoder.sv
// Directed bench for error_code_encoder; a second instance with DROP_W=2 covers saturation.
module tb_error_code_encoder;

  logic       clk = 1'b0;
  logic       rst, parity_evt, timeout_evt, overflow_evt, err_ready;
  logic [2:0] err_code, err_code2, pending, pending2;
  logic       err_valid, err_valid2, err_multi, err_multi2;
  logic [7:0] drop_cnt;
  logic [1:0] drop_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  error_code_encoder #(.DROP_W(8)) dut (
    .clk(clk), .rst(rst), .parity_evt(parity_evt), .timeout_evt(timeout_evt),
    .overflow_evt(overflow_evt), .err_code(err_code), .err_valid(err_valid),
    .err_ready(err_ready), .err_multi(err_multi), .pending(pending), .drop_cnt(drop_cnt)
  );

  error_code_encoder #(.DROP_W(2)) dut2 (
    .clk(clk), .rst(rst), .parity_evt(parity_evt), .timeout_evt(timeout_evt),
    .overflow_evt(overflow_evt), .err_code(err_code2), .err_valid(err_valid2),
    .err_ready(err_ready), .err_multi(err_multi2), .pending(pending2), .drop_cnt(drop_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; parity_evt = 1'b0; timeout_evt = 1'b0; overflow_evt = 1'b0; err_ready = 1'b0;

    // reset
    tick(); tick();
    chk("rst_valid",   32'(err_valid), 32'd0);
    chk("rst_pending", 32'(pending),   32'd0);
    chk("rst_drop",    32'(drop_cnt),  32'd0);
    chk("rst_code",    32'(err_code),  32'd0);
    chk("rst_multi",   32'(err_multi), 32'd0);
    rst = 1'b0;

    // single parity event
    err_ready = 1'b1;
    parity_evt = 1'b1; tick(); parity_evt = 1'b0;
    chk("par_pend_set", 32'(pending),   32'd1);
    chk("par_valid_n1", 32'(err_valid), 32'd0);
    tick();
    chk("par_valid",    32'(err_valid), 32'd1);
    chk("par_code",     32'(err_code),  32'd0);
    chk("par_multi",    32'(err_multi), 32'd0);
    chk("par_pend_clr", 32'(pending),   32'd0);
    tick();
    chk("par_valid_end", 32'(err_valid), 32'd0);

    // timeout + overflow together -> MULTI
    timeout_evt = 1'b1; overflow_evt = 1'b1; tick();
    timeout_evt = 1'b0; overflow_evt = 1'b0;
    chk("multi_pend", 32'(pending), 32'd6);
    tick();
    chk("multi_valid", 32'(err_valid), 32'd1);
    chk("multi_code",  32'(err_code),  32'd7);
    chk("multi_flag",  32'(err_multi), 32'd1);
    tick();
    chk("multi_end",   32'(err_valid), 32'd0);

    // overflow x3 with consumer stalled
    err_ready = 1'b0;
    overflow_evt = 1'b1; tick();
    tick();
    chk("ovf_valid",  32'(err_valid), 32'd1);
    chk("ovf_code",   32'(err_code),  32'd5);
    chk("ovf_rearm",  32'(pending),   32'd4);
    chk("ovf_drop0",  32'(drop_cnt),  32'd0);
    tick(); overflow_evt = 1'b0;
    chk("ovf_drop1",  32'(drop_cnt),  32'd1);
    tick();
    chk("ovf_hold_valid", 32'(err_valid), 32'd1);
    chk("ovf_hold_code",  32'(err_code),  32'd5);
    err_ready = 1'b1; tick();
    chk("ovf_b2b_valid", 32'(err_valid), 32'd1);
    chk("ovf_b2b_code",  32'(err_code),  32'd5);
    chk("ovf_b2b_pend",  32'(pending),   32'd0);
    tick();
    chk("ovf_end",       32'(err_valid), 32'd0);
    chk("ovf_drop_keep", 32'(drop_cnt),  32'd1);

    // saturation on the narrow counter
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    err_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      timeout_evt = 1'b1; tick(); timeout_evt = 1'b0; tick();
      if (k >= 3) begin
        chk($sformatf("sat_w8_%0d", k), 32'(drop_cnt),  32'(k - 2));
        chk($sformatf("sat_w2_%0d", k), 32'(drop_cnt2), (k - 2 > 3) ? 32'd3 : 32'(k - 2));
      end
    end
    chk("sat_code",  32'(err_code2), 32'd3);
    chk("sat_pend",  32'(pending2),  32'd2);

    // reset mid-handshake
    chk("mid_valid_pre", 32'(err_valid), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_valid", 32'(err_valid), 32'd0);
    chk("mid_pend",  32'(pending),   32'd0);
    chk("mid_drop",  32'(drop_cnt),  32'd0);
    chk("mid_code",  32'(err_code),  32'd0);
    err_ready = 1'b1; tick();
    chk("mid_idle",  32'(err_valid), 32'd0);

    // all three dropped in one cycle count independently
    err_ready = 1'b0;
    parity_evt = 1'b1; timeout_evt = 1'b1; overflow_evt = 1'b1; tick();
    parity_evt = 1'b0; timeout_evt = 1'b0; overflow_evt = 1'b0; tick();
    chk("tri_code",  32'(err_code),  32'd7);
    chk("tri_multi", 32'(err_multi), 32'd1);
    parity_evt = 1'b1; timeout_evt = 1'b1; overflow_evt = 1'b1; tick();
    chk("tri_drop0", 32'(drop_cnt), 32'd0);
    tick();
    parity_evt = 1'b0; timeout_evt = 1'b0; overflow_evt = 1'b0;
    chk("tri_drop3", 32'(drop_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
